// File: rtl/serial_rca_adder_if.sv
// Handshake and data bundle for the bit-serial ripple-carry adder.
// The master issues the operands and start; the slave returns status and result.
interface serial_rca_adder_if #(
  parameter int W = 32
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_rca_adder.sv
// Bit-serial ripple-carry adder: sum = a + b + cin, one bit per clock through a
// single full-adder cell and a registered carry. W cycles from accept to done,
// with back-to-back starts accepted in the DONE cycle (one result per W+1 cycles).
module serial_rca_adder #(
  parameter int W = 32
) (
  input logic             clk,
  input logic             rst_n,
  serial_rca_adder_if.slave bus
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST = IW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  psum;
  logic [IW-1:0] idx;
  logic          c;
  logic [1:0]    fa_out;

  // Single full-adder cell; returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic s;
    logic co;
    s  = x ^ y ^ ci;
    co = (x & y) | (ci & (x ^ y));
    return {co, s};
  endfunction

  // The operand registers shift right, so the bit under process is always bit 0.
  assign fa_out = full_add(a_sh[0], b_sh[0], c);

  // Control FSM plus serial datapath; every output is driven from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      psum     <= '0;
      idx      <= '0;
      c        <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            c        <= bus.cin;
            idx      <= '0;
            psum     <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately not looked at here: no restart, no queueing.
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c    <= fa_out[1];
          psum <= {fa_out[0], psum[W-1:1]};
          idx  <= idx + 1'b1;
          if (idx == LAST) begin
            // c here is the carry into the MSB; XOR with the carry out gives overflow.
            bus.sum  <= {fa_out[0], psum[W-1:1]};
            bus.cout <= fa_out[1];
            bus.ovf  <= c ^ fa_out[1];
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rca_adder.sv
// Scoreboard bench for serial_rca_adder at W = 8: stimulus pushes hand-computed
// results with their expected done cycle; a monitor pops on every done pulse.
module tb_serial_rca_adder;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    string      name;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         at;
  } exp_t;

  exp_t sb[$];

  serial_rca_adder_if #(.W(W)) bus ();

  serial_rca_adder #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      chk("busy_with_done", 32'(bus.busy), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_sum"}, 32'(bus.sum), 32'(e.sum));
        chk({e.name, "_cout"}, 32'(bus.cout), 32'(e.cout));
        chk({e.name, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.at));
      end
    end
  end

  // Drive start at the current negedge; it is accepted at the next rising edge.
  task automatic issue(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] s, input logic co,
                       input logic ov);
    exp_t e;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    e.name = name;
    e.sum  = s;
    e.cout = co;
    e.ovf  = ov;
    e.at   = cyc + 1 + W;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bus.busy || bus.done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy || bus.done) chk({name, "_timeout"}, 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_sum"}, 32'(bus.sum), 32'd0);
    chk({name, "_cout"}, 32'(bus.cout), 32'd0);
    chk({name, "_ovf"}, 32'(bus.ovf), 32'd0);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int bcnt;
    int m;
    int n;
    total     = 0;
    bad       = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add, with busy counted over the whole run.
    issue("basic", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
    end
    chk("basic_busy_cycles", 32'(bcnt), 32'd8);
    chk("basic_busy_low_at_done", 32'(bus.busy), 32'd0);
    wait_idle("basic");

    issue("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    wait_idle("ripple");
    issue("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    wait_idle("ovf_pos");
    issue("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    wait_idle("ovf_neg");
    issue("cin_wrap", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0);
    wait_idle("cin_wrap");

    // Carry-in then back-to-back start held in the DONE cycle.
    m = cyc;
    issue("b2b_first", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    n = 0;
    while (cyc != m + 1 + W && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_in_done_cycle", 32'(bus.done), 32'd1);
    issue("b2b_second", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    wait_idle("b2b");

    // start during RUN must be ignored.
    issue("ignore_start", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("ignore_start");
    repeat (4) @(negedge clk);

    // Reset in the middle of a run: outputs clear at once, no done follows.
    issue("aborted", 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_reset_sum", 32'(bus.sum), 32'd0);

    issue("after_reset", 8'h3C, 8'h4B, 1'b1, 8'h88, 1'b0, 1'b1);
    wait_idle("after_reset");

    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
